// File: rtl/seg7_pkg.sv
// Shared constants and types for the register-tap seven-segment display.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [2:0] digit_idx_t;

    localparam seg_t SEG_HEX_0 = 7'h40;
    localparam seg_t SEG_HEX_1 = 7'h79;
    localparam seg_t SEG_HEX_2 = 7'h24;
    localparam seg_t SEG_HEX_3 = 7'h30;
    localparam seg_t SEG_HEX_4 = 7'h19;
    localparam seg_t SEG_HEX_5 = 7'h12;
    localparam seg_t SEG_HEX_6 = 7'h02;
    localparam seg_t SEG_HEX_7 = 7'h78;
    localparam seg_t SEG_HEX_8 = 7'h00;
    localparam seg_t SEG_HEX_9 = 7'h10;
    localparam seg_t SEG_HEX_A = 7'h08;
    localparam seg_t SEG_HEX_B = 7'h03;
    localparam seg_t SEG_HEX_C = 7'h46;
    localparam seg_t SEG_HEX_D = 7'h21;
    localparam seg_t SEG_HEX_E = 7'h06;
    localparam seg_t SEG_HEX_F = 7'h0E;

    localparam seg_t        SEG_BLANK  = 7'h7F;
    localparam logic [7:0]  AN_OFF     = 8'hFF;
    localparam int unsigned NUM_DIGITS = 32'd8;

    // Active-low one-hot anode pattern for a digit slot.
    function automatic logic [7:0] digit_anode(input digit_idx_t idx);
        return ~(8'b0000_0001 << idx);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Purely combinational nibble to active-low seven-segment hex encoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    // Hex glyph lookup.
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0:    seg = SEG_HEX_0;
            4'h1:    seg = SEG_HEX_1;
            4'h2:    seg = SEG_HEX_2;
            4'h3:    seg = SEG_HEX_3;
            4'h4:    seg = SEG_HEX_4;
            4'h5:    seg = SEG_HEX_5;
            4'h6:    seg = SEG_HEX_6;
            4'h7:    seg = SEG_HEX_7;
            4'h8:    seg = SEG_HEX_8;
            4'h9:    seg = SEG_HEX_9;
            4'hA:    seg = SEG_HEX_A;
            4'hB:    seg = SEG_HEX_B;
            4'hC:    seg = SEG_HEX_C;
            4'hD:    seg = SEG_HEX_D;
            4'hE:    seg = SEG_HEX_E;
            4'hF:    seg = SEG_HEX_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_reg_display.sv
// Multiplexed 8-digit hex display of the CPU v0/v1 taps with a frame-aligned
// snapshot, freeze, leading-zero blanking and a change pulse.
module seg7_reg_display
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 32'd100000,
    parameter int unsigned SYNC_STAGES = 32'd2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] v0_In,
    input  logic [31:0] v1_In,
    input  logic        Sel,
    input  logic        Freeze,
    input  logic        Blank_En,
    output logic [7:0]  An,
    output logic [6:0]  Seg,
    output logic        Dp,
    output logic        Update_Pulse
);

    localparam int unsigned      PRE_W       = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(REFRESH_DIV - 32'd1);
    localparam digit_idx_t       DIGIT_LAST  = digit_idx_t'(NUM_DIGITS - 32'd1);

    // Each stage carries {blank_en, freeze, sel}.
    logic [SYNC_STAGES-1:0][2:0] sw_sync_r;
    logic [PRE_W-1:0]            prescaler_r;
    digit_idx_t                  digit_idx_r;
    logic [31:0]                 snapshot_r;
    logic                        update_r;
    logic [7:0]                  an_r;
    seg_t                        seg_r;
    logic                        dp_r;

    logic                  sel_s;
    logic                  freeze_s;
    logic                  blank_en_s;
    logic                  tc_s;
    logic                  frame_end_s;
    logic [31:0]           next_snap_s;
    logic [3:0]            nibble_s;
    seg_t                  hex_seg_s;
    logic [NUM_DIGITS-1:0] lead_zero_s;
    logic                  blank_s;

    assign sel_s       = sw_sync_r[SYNC_STAGES-1][0];
    assign freeze_s    = sw_sync_r[SYNC_STAGES-1][1];
    assign blank_en_s  = sw_sync_r[SYNC_STAGES-1][2];
    assign tc_s        = (prescaler_r == PRE_LAST);
    assign frame_end_s = tc_s && (digit_idx_r == DIGIT_LAST);
    assign next_snap_s = sel_s ? v1_In : v0_In;
    assign nibble_s    = snapshot_r[{digit_idx_r, 2'b00} +: 4];

    // Switch synchronisers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sw_sync_r <= '0;
        end else begin
            sw_sync_r[0] <= {Blank_En, Freeze, Sel};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sw_sync_r[i] <= sw_sync_r[i-1];
            end
        end
    end

    // Refresh prescaler and digit scan counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            prescaler_r <= '0;
            digit_idx_r <= '0;
        end else if (tc_s) begin
            prescaler_r <= '0;
            digit_idx_r <= digit_idx_r + 3'd1;
        end else begin
            prescaler_r <= prescaler_r + PRE_W'(1'b1);
        end
    end

    // Snapshot only reloads between frames so a frame never mixes two values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            snapshot_r <= 32'd0;
            update_r   <= 1'b0;
        end else if (frame_end_s && !freeze_s) begin
            snapshot_r <= next_snap_s;
            update_r   <= (next_snap_s != snapshot_r);
        end else begin
            update_r   <= 1'b0;
        end
    end

    // Digit k is a leading zero when every nibble from k upward is zero; digit 0 never is.
    always_comb begin
        lead_zero_s = '0;
        for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
            lead_zero_s[k] = ((snapshot_r >> (4 * k)) == 32'd0);
        end
    end

    // Blank decision for the digit currently being scanned.
    always_comb begin
        blank_s = 1'b0;
        if (blank_en_s) begin
            blank_s = lead_zero_s[digit_idx_r];
        end else begin
            blank_s = 1'b0;
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble_s),
        .seg    (hex_seg_s)
    );

    // Registered display drive.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            an_r  <= AN_OFF;
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= digit_anode(digit_idx_r);
            seg_r <= blank_s ? SEG_BLANK : hex_seg_s;
            dp_r  <= !((digit_idx_r == DIGIT_LAST) && freeze_s);
        end
    end

    assign An           = an_r;
    assign Seg          = seg_r;
    assign Dp           = dp_r;
    assign Update_Pulse = update_r;

endmodule

// File: tb/tb_seg7_reg_display.sv
// Directed frame-by-frame bench for seg7_reg_display with REFRESH_DIV=4.
module tb_seg7_reg_display;

    localparam logic [55:0] ZERO = {8{7'h40}};
    localparam logic [55:0] ABCD = {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21};
    localparam logic [55:0] F0BL = {{6{7'h7F}}, 7'h0E, 7'h40};
    localparam logic [55:0] Z_BL = {{7{7'h7F}}, 7'h40};
    localparam logic [55:0] FIVE = {{7{7'h40}}, 7'h12};
    localparam logic [55:0] SIX  = {{7{7'h40}}, 7'h02};
    localparam logic [55:0] ONE  = {{7{7'h40}}, 7'h79};
    localparam logic [55:0] TWO  = {{7{7'h40}}, 7'h24};

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] v0;
    logic [31:0] v1;
    logic        sel;
    logic        frz;
    logic        blank;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        upd;

    int checks = 0;
    int errors = 0;

    seg7_reg_display #(
        .REFRESH_DIV (32'd4),
        .SYNC_STAGES (32'd2)
    ) dut (
        .Clk          (clk),
        .Reset        (rst),
        .v0_In        (v0),
        .v1_In        (v1),
        .Sel          (sel),
        .Freeze       (frz),
        .Blank_En     (blank),
        .An           (an),
        .Seg          (seg),
        .Dp           (dp),
        .Update_Pulse (upd)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Sample n cycles of a frame starting right after its first edge.
    task automatic check_frame(input string tag, input logic [55:0] segs, input bit frozen,
                               input int exp_pulses, input int n, input int sel_at);
        int         pulses;
        int         d;
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d       = i / 4;
            exp_an  = ~(8'h01 << d);
            exp_seg = segs[d*7 +: 7];
            exp_dp  = (frozen && d == 7) ? 1'b0 : 1'b1;
            check_val($sformatf("%s_an%0d", tag, i), {24'd0, an}, {24'd0, exp_an});
            check_val($sformatf("%s_seg%0d", tag, i), {25'd0, seg}, {25'd0, exp_seg});
            check_val($sformatf("%s_dp%0d", tag, i), {31'd0, dp}, {31'd0, exp_dp});
            if (upd === 1'b1) pulses++;
            if (i == sel_at) sel = 1'b1;
        end
        check_val($sformatf("%s_pulses", tag), pulses, exp_pulses);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_an"}, {24'd0, an}, 32'h0000_00FF);
        check_val({tag, "_seg"}, {25'd0, seg}, 32'h0000_007F);
        check_val({tag, "_dp"}, {31'd0, dp}, 32'd1);
        check_val({tag, "_upd"}, {31'd0, upd}, 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        v0    = 32'd0;
        v1    = 32'd0;
        sel   = 1'b0;
        frz   = 1'b0;
        blank = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        check_frame("f0_zero", ZERO, 1'b0, 0, 32, -1);
        v0 = 32'h1234_ABCD;
        check_frame("f1_load", ZERO, 1'b0, 1, 32, -1);
        check_frame("f2_hex", ABCD, 1'b0, 0, 32, -1);
        v0    = 32'h0000_00F0;
        blank = 1'b1;
        check_frame("f3_hex_blanken", ABCD, 1'b0, 1, 32, -1);
        v0 = 32'd0;
        check_frame("f4_blank_f0", F0BL, 1'b0, 1, 32, -1);
        check_frame("f5_blank_zero", Z_BL, 1'b0, 0, 32, -1);
        v0    = 32'h5;
        blank = 1'b0;
        check_frame("f6_load5", ZERO, 1'b0, 1, 32, -1);
        frz = 1'b1;
        v0  = 32'h6;
        check_frame("f7_frozen", FIVE, 1'b1, 0, 32, -1);
        check_frame("f8_frozen", FIVE, 1'b1, 0, 32, -1);
        frz = 1'b0;
        check_frame("f9_unfreeze", FIVE, 1'b0, 1, 32, -1);
        check_frame("f10_six", SIX, 1'b0, 0, 32, -1);
        v0 = 32'h1;
        v1 = 32'h2;
        check_frame("f11_load1", SIX, 1'b0, 1, 32, -1);
        check_frame("f12_sel_mid", ONE, 1'b0, 1, 32, 13);
        check_frame("f13_v1", TWO, 1'b0, 0, 32, -1);
        check_frame("f14_partial", TWO, 1'b0, 0, 22, -1);

        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midscan_reset");
        rst = 1'b0;
        check_frame("f15_after_reset", ZERO, 1'b0, 1, 32, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
